// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcodes, control codes.
// Used by the operand-issue stage and the ALU.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MULT = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_INV  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MULT = 4'h2,
    ALU_SLL  = 4'h3,
    ALU_SRL  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_SLT  = 4'h7,
    ALU_XOR  = 4'h8,
    ALU_INV  = 4'h9
  } alu_ctl_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        ctl;
    logic [ADDR_W-1:0] rd;
    logic              wr;
  } issue_t;

  function automatic logic [DATA_W-1:0] sext6(
    input logic [5:0] imm
  );
    return {{(DATA_W-6){imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_issue_reg_file.sv
// 8x16 register file: one write port, two async read ports.
// R0 is never written and always reads zero.
module reg_file
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata0 = (raddr0 == '0) ? '0 : mem_q[raddr0];
  assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];

endmodule

// File: rtl/alu_operand_issue.sv
// Decode/operand-issue stage feeding the 16-bit ALU.
// Forwarding from EX and WB, single-entry output register.
module alu_operand_issue
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_fwd_en,
  input  logic [ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0] ex_fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr,
  output logic              illegal
);

  logic [3:0]        op;
  logic [ADDR_W-1:0] rd, rs, rt;
  logic [5:0]        imm6;
  logic [DATA_W-1:0] rf_s, rf_t, opa, opb;
  logic              accept;
  issue_t            dec, out_d, out_q;
  logic              dec_ill;
  logic              valid_d, valid_q;
  logic              ill_d, ill_q;

  assign op   = in_instr[15:12];
  assign rd   = in_instr[11:9];
  assign rs   = in_instr[8:6];
  assign rt   = in_instr[5:3];
  assign imm6 = in_instr[5:0];

  reg_file u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr0 (rs),
    .rdata0 (rf_s),
    .raddr1 (rt),
    .rdata1 (rf_t)
  );

  // Youngest producer wins: EX result over the value being written back.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] rf,
    input logic              xe,
    input logic [ADDR_W-1:0] xa,
    input logic [DATA_W-1:0] xd,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (ra == '0)            return '0;
    else if (xe && xa == ra) return xd;
    else if (we && wa == ra) return wd;
    else                     return rf;
  endfunction

  always_comb begin
    opa = fwd(rs, rf_s, ex_fwd_en, ex_fwd_addr,
              ex_fwd_data, wb_en, wb_addr, wb_data);
    opb = fwd(rt, rf_t, ex_fwd_en, ex_fwd_addr,
              ex_fwd_data, wb_en, wb_addr, wb_data);
  end

  always_comb begin
    dec     = '{a: opa, b: opb, ctl: op, rd: rd, wr: 1'b1};
    dec_ill = 1'b0;
    unique case (op)
      OP_ADDI: begin
        dec.ctl = ALU_ADD;
        dec.b   = sext6(imm6);
      end
      OP_NOP: begin
        dec.a   = '0;
        dec.b   = '0;
        dec.ctl = ALU_ADD;
        dec.wr  = 1'b0;
      end
      4'hB, 4'hC, 4'hD, 4'hE: begin
        dec.a   = '0;
        dec.b   = '0;
        dec.ctl = ALU_ADD;
        dec.wr  = 1'b0;
        dec_ill = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    ill_d   = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      out_d   = dec;
      ill_d   = dec_ill;
    end else if (flush || out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_a       = out_q.a;
  assign alu_b       = out_q.b;
  assign alu_control = out_q.ctl;
  assign out_rd      = out_q.rd;
  assign out_wr      = out_q.wr;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed vectors, an
// instruction-level reference model and literal spot values.
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic [15:0] in_instr;
  logic        wb_en, ex_fwd_en;
  logic [2:0]  wb_addr, ex_fwd_addr;
  logic [15:0] wb_data, ex_fwd_data;
  logic        out_valid, out_ready;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [2:0]  out_rd;
  logic        out_wr, illegal;

  int checks = 0;
  int errors = 0;

  alu_operand_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_fwd_en   (ex_fwd_en),
    .ex_fwd_addr (ex_fwd_addr),
    .ex_fwd_data (ex_fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .out_rd      (out_rd),
    .out_wr      (out_wr),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural registers plus one held entry.
  logic [15:0] m_regs [8];
  logic        m_valid = 0, m_wr = 0, m_ill = 0;
  logic [15:0] m_a = 0, m_b = 0;
  logic [3:0]  m_ctl = 0;
  logic [2:0]  m_rd = 0;

  initial for (int i = 0; i < 8; i++) m_regs[i] = 0;

  function automatic logic [15:0] m_read(input logic [2:0] r);
    if (r == 0) return 16'h0;
    if (ex_fwd_en && ex_fwd_addr == r) return ex_fwd_data;
    if (wb_en && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_ctl = 0;
      m_rd = 0; m_wr = 0; m_ill = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
    end else begin
      int op;
      op = int'(in_instr[15:12]);
      if (in_valid && (!m_valid || out_ready) && !flush) begin
        m_valid = 1;
        m_rd    = in_instr[11:9];
        m_ill   = 0;
        if (op <= 9) begin
          m_ctl = op[3:0];
          m_a = m_read(in_instr[8:6]);
          m_b = m_read(in_instr[5:3]);
          m_wr = 1;
        end else if (op == 10) begin
          m_ctl = 0;
          m_a = m_read(in_instr[8:6]);
          m_b = 16'(signed'(in_instr[5:0]));
          m_wr = 1;
        end else begin
          m_ctl = 0; m_a = 0; m_b = 0; m_wr = 0;
          m_ill = (op != 15);
        end
      end else begin
        m_ill = 0;
        if (flush || out_ready) m_valid = 0;
      end
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("illegal", illegal, m_ill);
    if (m_valid) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_control", alu_control, m_ctl);
      chk("out_rd", out_rd, m_rd);
      chk("out_wr", out_wr, m_wr);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] ins(
    input logic [3:0] op, input logic [2:0] d,
    input logic [2:0] s, input logic [2:0] t);
    return {op, d, s, t, 3'b000};
  endfunction

  initial begin
    rst_n = 1; in_valid = 0; in_instr = 0; flush = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    ex_fwd_en = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    out_ready = 1;
    #1 rst_n = 0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1;
    tick();

    wb_en = 1; wb_addr = 1; wb_data = 16'h0005; tick();
    wb_addr = 2; wb_data = 16'h0003; tick();
    wb_en = 0;

    in_valid = 1; in_instr = ins(4'h1, 3, 1, 2); tick();
    in_valid = 0;
    chk("sub_valid", out_valid, 1);
    chk("sub_a", alu_a, 16'h0005);
    chk("sub_b", alu_b, 16'h0003);
    chk("sub_ctl", alu_control, 4'h1);
    chk("sub_rd", out_rd, 3);
    chk("sub_wr", out_wr, 1);

    in_valid = 1; in_instr = {4'hA, 3'd5, 3'd1, 6'b111110}; tick();
    chk("addi_b", alu_b, 16'hFFFE);
    chk("addi_ctl", alu_control, 4'h0);
    chk("addi_a", alu_a, 16'h0005);

    in_instr = ins(4'h0, 6, 2, 0);
    ex_fwd_en = 1; ex_fwd_addr = 2; ex_fwd_data = 16'hBEEF;
    wb_en = 1; wb_addr = 2; wb_data = 16'h1111; tick();
    chk("fwd_ex", alu_a, 16'hBEEF);
    ex_fwd_en = 0; tick();
    chk("fwd_wb", alu_a, 16'h1111);
    in_instr = ins(4'h6, 6, 4, 1);
    wb_addr = 4; wb_data = 16'h4444; tick();
    chk("bypass_a", alu_a, 16'h4444);
    chk("bypass_b", alu_b, 16'h0005);
    wb_en = 0; in_valid = 0; tick();

    out_ready = 0; in_valid = 1;
    in_instr = ins(4'h8, 1, 1, 2); tick();
    in_instr = ins(4'h5, 2, 1, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", in_ready, 0);
      chk("bp_hold", alu_control, 4'h8);
    end
    out_ready = 1; tick();
    chk("bp_next", alu_control, 4'h5);
    chk("bp_next_b", alu_b, 16'h4444);
    in_valid = 0; tick();
    chk("bp_nodup", out_valid, 0);

    in_valid = 1; in_instr = ins(4'hC, 7, 1, 2); tick();
    in_valid = 0;
    chk("ill_pulse", illegal, 1);
    chk("ill_wr", out_wr, 0);
    chk("ill_ctl", alu_control, 0);
    tick();
    chk("ill_once", illegal, 0);
    in_valid = 1; flush = 1; tick();
    chk("ill_flush", illegal, 0);
    chk("ill_flush_v", out_valid, 0);
    flush = 0; out_ready = 0;
    in_instr = ins(4'h2, 3, 1, 2); tick();
    in_valid = 0; flush = 1; tick();
    chk("flush_held", out_valid, 0);
    flush = 0; out_ready = 1; tick();

    out_ready = 0; in_valid = 1;
    in_instr = ins(4'h0, 7, 1, 2); tick();
    in_valid = 0;
    chk("pre_rst_v", out_valid, 1);
    #2 rst_n = 0;
    #1 chk("async_rst", out_valid, 0);
    tick();
    rst_n = 1; out_ready = 1; tick();
    in_valid = 1; in_instr = ins(4'h0, 4, 1, 2); tick();
    in_valid = 0;
    chk("r1_cleared", alu_a, 0);
    chk("r2_cleared", alu_b, 0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Decode/operand-issue stage directly upstream of the 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes the opcode into the 4-bit ALU control code.
- Reads operands from an internal 8x16 register file, with forwarding from EX and writeback.
- Presents registered A, B, alu_control and destination to the ALU through a single-entry pipeline register.

Parameters:
- DATA_W, 16, operand/result width (fixed to match the ALU).
- NREGS, 8, number of architectural registers; R0 reads as zero.
- ADDR_W, 3, register address width (clog2 of NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  16  instruction: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [5:0] imm6.
- flush  in  1  drop the held output entry and any same-cycle acceptance.
- wb_en  in  1  register-file write enable.
- wb_addr  in  3  write address.
- wb_data  in  16  write data.
- ex_fwd_en  in  1  EX-stage result valid for forwarding.
- ex_fwd_addr  in  3  EX destination register.
- ex_fwd_data  in  16  EX result.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  ALU/EX stage accepts the operands.
- alu_a  out  16  operand A to ALU.
- alu_b  out  16  operand B to ALU.
- alu_control  out  4  ALU operation code.
- out_rd  out  3  destination register.
- out_wr  out  1  result is to be written back (0 for NOP/illegal).
- illegal  out  1  one-cycle pulse on acceptance of an undefined opcode.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid=0, alu_a=0, alu_b=0, alu_control=0000, out_rd=0, out_wr=0, illegal=0.
  - All registers cleared to 0.
- Handshake:
  - in_ready = !out_valid || out_ready. Combinational, no dependence on in_valid.
  - Accept = in_valid && in_ready && !flush.
  - Output register loads on Accept. Latency is 1 cycle from accept to out_valid.
  - Output holds stable while out_valid && !out_ready.
  - If out_ready is asserted and there is no Accept, out_valid clears.
- Decode:
  - Op 0000–1001 passes straight through to alu_control: add, sub, mult, sll, srl, and, or, slt, xor, invert.
  - For these ops: A = reg[rs], B = reg[rt], out_wr=1.
  - Op 1010 (ADDI): alu_control=0000, A = reg[rs], B = sign-extended imm6 (e.g. 6'b111111 -> 16'hFFFF), out_wr=1.
  - Op 1111 (NOP): alu_control=0000, A=B=0, out_wr=0.
  - Ops 1011–1110 are illegal: issued as NOP with out_wr=0, and illegal pulses for one cycle on Accept.
- Operand source priority, per read port:
  1. Address 0 reads 0.
  2. ex_fwd_en with a matching address uses ex_fwd_data.
  3. wb_en with a matching address uses wb_data (write-through bypass).
  4. Otherwise the register-file contents.
- Register file:
  - Synchronous write on a clk edge when wb_en is high. Writes to address 0 are ignored.
  - Two combinational read ports.
- Flush:
  - At the next edge out_valid=0.
  - The instruction presented that cycle is dropped and no illegal pulse is generated.
  - Register-file writes in the same cycle still occur.
- Simultaneous flush and out_ready: flush wins, out_valid=0.
- Reset asserted mid-operation clears the held entry immediately; it is not completed.
- Arithmetic: no width change. Immediates are sign-extended from bit 5.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants: OP_ADD…OP_INV, OP_ADDI=1010, OP_NOP=1111.
  - ALU control encodings, DATA_W, ADDR_W.
  - The ALU uses the same package.
- One sub-module, reg_file: NREGS x DATA_W, 2 read ports and 1 write port, R0 hardwired to zero, async reset.
- Forwarding muxes and decode stay in the top module.

Test Plan:
- Reset, then write R1=0x0005 and R2=0x0003 via wb. Issue op 0001 (rd=3, rs=1, rt=2) -> the next cycle shows out_valid=1, A=0x0005, B=0x0003, alu_control=0001, out_rd=3, out_wr=1.
- ADDI rs=1, imm6=111110 -> B=0xFFFE, alu_control=0000.
- Issue with rs=2 while ex_fwd_en=1, ex_fwd_addr=2, ex_fwd_data=0xBEEF, and wb_en=1 to R2 with 0x1111 in the same cycle -> A=0xBEEF. In a repeat with ex_fwd_en=0 -> A=0x1111.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Then raise out_ready=1 -> the next instruction loads on the following edge with no loss or duplication.
- Op 1100 -> illegal high for exactly one cycle, out_wr=0, alu_control=0000. Op 1100 with flush=1 -> no pulse and out_valid=0.
- Assert rst_n=0 asynchronously while out_valid=1 and out_ready=0 -> out_valid drops without waiting for a clock edge. A subsequent read of R1 returns 0x0000.
